sram_responder: RTL and testbench



---
 rtl/sram_responder.sv | 136 +++++++++++++
 tb/tb_sram_responder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_responder.sv
// SRAM-side bus responder: write/read array with fixed-latency read return,
// post-reset clear sequence, and collision/drop flags for the bus monitor.
module sram_responder #(
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned RD_LAT         = 1,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic              rd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              busy,
  output logic              coll,
  output logic              drop
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam logic        CLEAR = (CLEAR_ON_RESET != 0);

  typedef enum logic {INIT, READY} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              clr_we;
  logic              acc_wr;
  logic              acc_rd;
  logic              coll_nxt;
  logic              drop_nxt;
  logic              pre_v;
  logic [DATA_W-1:0] pre_d;

  // State register; reset lands in INIT only when a clear is wanted
  always_ff @(posedge clk) begin
    if (rst) state <= CLEAR ? INIT : READY;
    else     state <= state_nxt;
  end

  // Leave INIT on the edge that clears the last address
  always_comb begin
    state_nxt = state;
    if (state == INIT && (&cnt)) state_nxt = READY;
  end

  // Command decode: INIT swallows commands, READY rejects wr+rd together
  always_comb begin
    clr_we   = 1'b0;
    acc_wr   = 1'b0;
    acc_rd   = 1'b0;
    coll_nxt = 1'b0;
    drop_nxt = 1'b0;
    if (state == INIT) begin
      clr_we   = 1'b1;
      drop_nxt = wr | rd;
    end else begin
      coll_nxt = wr & rd;
      acc_wr   = wr & ~rd;
      acc_rd   = rd & ~wr;
    end
  end

  // Clear address counter, wraps to 0 after the last address
  always_ff @(posedge clk) begin
    if (rst)         cnt <= '0;
    else if (clr_we) cnt <= cnt + ADDR_W'(1);
  end

  // Status flags; busy mirrors whether the next state is still clearing
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= CLEAR;
      coll <= 1'b0;
      drop <= 1'b0;
    end else begin
      busy <= (state_nxt == INIT);
      coll <= coll_nxt;
      drop <= drop_nxt;
    end
  end

  // Array write port: clear has priority; nothing is written in a reset cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clr_we)      mem[cnt]  <= '0;
      else if (acc_wr) mem[addr] <= wdata;
    end
  end

  // Read pipeline ahead of the output register (RD_LAT-1 stages)
  if (RD_LAT == 1) begin : g_lat1
    assign pre_v = acc_rd;
    assign pre_d = mem[addr];
  end else begin : g_latn
    localparam int unsigned NST = RD_LAT - 1;
    logic [NST-1:0]    pv;
    logic [DATA_W-1:0] pd [NST];

    // Valid shift chain, flushed by reset
    always_ff @(posedge clk) begin
      if (rst) begin
        pv <= '0;
      end else begin
        pv[0] <= acc_rd;
        for (int i = 1; i < int'(NST); i++) pv[i] <= pv[i-1];
      end
    end

    // Data shift chain; array sampled at the edge that accepts the read
    always_ff @(posedge clk) begin
      pd[0] <= mem[addr];
      for (int i = 1; i < int'(NST); i++) pd[i] <= pd[i-1];
    end

    assign pre_v = pv[NST-1];
    assign pre_d = pd[NST-1];
  end

  // Output register; rdata holds the last returned value between strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid <= 1'b0;
      rdata  <= '0;
    end else begin
      rvalid <= pre_v;
      if (pre_v) rdata <= pre_d;
    end
  end

endmodule

// File: tb/tb_sram_responder.sv
// Bench for sram_responder: three instances (RD_LAT 1, 3, 4) share one
// stimulus stream and are checked every cycle against a queue-based model.
module tb_sram_responder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr = 1'b0;
  logic       rd = 1'b0;
  logic [7:0] addr = 8'h00;
  logic [7:0] wdata = 8'h00;

  logic [7:0] rdata_w  [3];
  logic       rvalid_w [3];
  logic       busy_w   [3];
  logic       coll_w   [3];
  logic       drop_w   [3];

  localparam int LAT0 = 1;
  localparam int LAT1 = 3;
  localparam int LAT2 = 4;

  always #5 clk = ~clk;

  sram_responder #(.ADDR_W(8), .DATA_W(8), .RD_LAT(LAT0), .CLEAR_ON_RESET(1)) u_l1 (
    .clk(clk), .rst(rst), .wr(wr), .rd(rd), .addr(addr), .wdata(wdata),
    .rdata(rdata_w[0]), .rvalid(rvalid_w[0]), .busy(busy_w[0]), .coll(coll_w[0]), .drop(drop_w[0]));
  sram_responder #(.ADDR_W(8), .DATA_W(8), .RD_LAT(LAT1), .CLEAR_ON_RESET(1)) u_l3 (
    .clk(clk), .rst(rst), .wr(wr), .rd(rd), .addr(addr), .wdata(wdata),
    .rdata(rdata_w[1]), .rvalid(rvalid_w[1]), .busy(busy_w[1]), .coll(coll_w[1]), .drop(drop_w[1]));
  sram_responder #(.ADDR_W(8), .DATA_W(8), .RD_LAT(LAT2), .CLEAR_ON_RESET(1)) u_l4 (
    .clk(clk), .rst(rst), .wr(wr), .rd(rd), .addr(addr), .wdata(wdata),
    .rdata(rdata_w[2]), .rvalid(rvalid_w[2]), .busy(busy_w[2]), .coll(coll_w[2]), .drop(drop_w[2]));

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string nm, input int k, input int act, input int exp);
    n_total++;
    if (act != exp) $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h (t=%0t)", nm, k, act, exp, $time);
    else n_pass++;
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { int issue; int data; } rd_t;
  rd_t q[$];
  int  hd [3];
  int  lat [3];
  int  mm [256];
  int  cyc = 0;
  int  clear_left = 0;
  bit  mvalid = 1'b0;
  int  erv [3];
  int  erd [3];
  int  ebusy = 0;
  int  ecoll = 0;
  int  edrop = 0;

  initial begin
    lat[0] = LAT0; lat[1] = LAT1; lat[2] = LAT2;
  end

  // Expected outputs after each edge: a read issued at edge c appears after
  // edge c+L-1; reset discards everything queued and restarts the clear.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      mvalid = 1'b1;
      q.delete();
      for (int k = 0; k < 3; k++) begin hd[k] = 0; erv[k] = 0; erd[k] = 0; end
      clear_left = 256;
      ebusy = 1; ecoll = 0; edrop = 0;
    end else begin
      if (clear_left > 0) begin
        mm[256 - clear_left] = 0;
        clear_left--;
        ebusy = (clear_left > 0) ? 1 : 0;
        edrop = (wr || rd) ? 1 : 0;
        ecoll = 0;
      end else begin
        edrop = 0;
        ecoll = (wr && rd) ? 1 : 0;
        if (wr && !rd) mm[addr] = int'(wdata);
        if (rd && !wr) q.push_back('{issue: cyc, data: mm[addr]});
      end
      for (int k = 0; k < 3; k++) begin
        erv[k] = 0;
        if (hd[k] < q.size() && q[hd[k]].issue + lat[k] - 1 == cyc) begin
          erv[k] = 1;
          erd[k] = q[hd[k]].data;
          hd[k]++;
        end
      end
    end
  end

  int rv_cnt [3] = '{0, 0, 0};

  // Compare every DUT output against the model between edges
  always @(negedge clk) begin
    if (mvalid) begin
      for (int k = 0; k < 3; k++) begin
        chk("rvalid", k, int'(rvalid_w[k]), erv[k]);
        chk("rdata",  k, int'(rdata_w[k]),  erd[k]);
        chk("busy",   k, int'(busy_w[k]),   ebusy);
        chk("coll",   k, int'(coll_w[k]),   ecoll);
        chk("drop",   k, int'(drop_w[k]),   edrop);
        if (rvalid_w[k]) rv_cnt[k]++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit r, input bit w, input bit rr, input int a, input int d);
    rst = r; wr = w; rd = rr; addr = 8'(a); wdata = 8'(d);
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
  endtask

  task automatic chk_rdata_all(input string nm, input int exp);
    for (int k = 0; k < 3; k++) chk(nm, k, int'(rdata_w[k]), exp);
  endtask

  int snap [3];
  task automatic take_snap();
    for (int k = 0; k < 3; k++) snap[k] = rv_cnt[k];
  endtask
  task automatic chk_rv_delta(input string nm, input int exp);
    for (int k = 0; k < 3; k++) chk(nm, k, rv_cnt[k] - snap[k], exp);
  endtask

  int bc;
  int dc;
  int seen [3];

  initial begin
    // Reset, then hammer writes of 0xFF during the clear
    drive(1'b1, 1'b0, 1'b0, 0, 0);
    drive(1'b1, 1'b0, 1'b0, 0, 0);
    for (int k = 0; k < 3; k++) chk("reset_busy", k, int'(busy_w[k]), 1);
    for (int k = 0; k < 3; k++) chk("reset_rvalid", k, int'(rvalid_w[k]), 0);
    bc = int'(busy_w[0]);
    dc = 0;
    for (int i = 0; i < 256; i++) begin
      drive(1'b0, 1'b1, 1'b0, i, 8'hFF);
      bc += int'(busy_w[0]);
      dc += int'(drop_w[0]);
    end
    chk("clear_busy_cycles", 0, bc, 256);
    chk("clear_drops", 0, dc, 256);
    for (int k = 0; k < 3; k++) chk("busy_after_clear", k, int'(busy_w[k]), 0);
    for (int i = 0; i < 256; i++) drive(1'b0, 1'b0, 1'b1, i, 0);
    idle(6);
    chk_rdata_all("cleared_read", 8'h00);

    // Basic latency: write 0xA5 to 0x3C, read it back, measure return offset
    drive(1'b0, 1'b1, 1'b0, 8'h3C, 8'hA5);
    take_snap();
    drive(1'b0, 1'b0, 1'b1, 8'h3C, 0);
    for (int k = 0; k < 3; k++) seen[k] = -1;
    for (int t = 0; t < 6; t++) begin
      for (int k = 0; k < 3; k++) if (rvalid_w[k] && seen[k] < 0) seen[k] = t;
      idle(1);
    end
    chk("lat_offset", 0, seen[0], 0);
    chk("lat_offset", 1, seen[1], 2);
    chk("lat_offset", 2, seen[2], 3);
    chk_rv_delta("basic_rvalid_count", 1);
    chk_rdata_all("basic_rdata", 8'hA5);

    // Back-to-back reads of 0..15 after filling i^0x5A
    for (int i = 0; i < 16; i++) drive(1'b0, 1'b1, 1'b0, i, i ^ 8'h5A);
    take_snap();
    for (int i = 0; i < 16; i++) drive(1'b0, 1'b0, 1'b1, i, 0);
    idle(6);
    chk_rv_delta("b2b_rvalid_count", 16);
    chk_rdata_all("b2b_last", 8'h55);

    // Collision leaves the array untouched and returns nothing
    drive(1'b0, 1'b1, 1'b0, 8'h10, 8'h11);
    take_snap();
    drive(1'b0, 1'b1, 1'b1, 8'h10, 8'h22);
    for (int k = 0; k < 3; k++) chk("coll_pulse", k, int'(coll_w[k]), 1);
    idle(1);
    for (int k = 0; k < 3; k++) chk("coll_one_cycle", k, int'(coll_w[k]), 0);
    idle(5);
    chk_rv_delta("coll_no_rvalid", 0);
    drive(1'b0, 1'b0, 1'b1, 8'h10, 0);
    idle(6);
    chk_rdata_all("coll_preserved", 8'h11);

    // Read-then-write hazard: the read sees the old value
    drive(1'b0, 1'b1, 1'b0, 8'h80, 8'h01);
    drive(1'b0, 1'b0, 1'b1, 8'h80, 0);
    drive(1'b0, 1'b1, 1'b0, 8'h80, 8'h02);
    idle(6);
    chk_rdata_all("hazard_old", 8'h01);
    drive(1'b0, 1'b0, 1'b1, 8'h80, 0);
    idle(6);
    chk_rdata_all("hazard_new", 8'h02);

    // Reset with reads in flight: nothing returns, clear restarts
    drive(1'b0, 1'b0, 1'b1, 8'h3C, 0);
    drive(1'b0, 1'b0, 1'b1, 8'h80, 0);
    drive(1'b0, 1'b0, 1'b1, 8'h10, 0);
    drive(1'b1, 1'b0, 1'b0, 0, 0);
    take_snap();
    bc = int'(busy_w[2]);
    for (int i = 0; i < 255; i++) begin
      idle(1);
      bc += int'(busy_w[2]);
    end
    idle(1);
    chk_rv_delta("reset_discard", 0);
    chk("reset_busy_cycles", 2, bc, 256);
    for (int k = 0; k < 3; k++) chk("reset_rdata_zero", k, int'(rdata_w[k]), 0);
    for (int i = 0; i < 256; i++) drive(1'b0, 1'b0, 1'b1, i, 0);
    idle(6);
    chk_rdata_all("reset_cleared_read", 8'h00);

    // Randomized traffic on a small address window, occasional reset
    for (int i = 0; i < 3000; i++) begin
      int sel;
      sel = int'($urandom_range(0, 9));
      drive(($urandom_range(0, 599) == 0),
            (sel < 4) || (sel == 9),
            (sel >= 4 && sel < 8) || (sel == 9),
            int'($urandom_range(0, 15)),
            int'($urandom_range(0, 255)));
    end
    idle(8);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
